// File: rtl/alu_seq.sv
// Registered, handshaked ALU: seven single-cycle ops plus an iterative shift-add multiply.
// Result and carry/zero/negative/overflow flags are registered and updated together with out_valid.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             carry_out,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             ovf_flag
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned PW    = 2 * WIDTH;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               valid_q, valid_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH:0]     sum_add, sum_sub;
  logic [PW-1:0]      acc_sum;
  logic [WIDTH-1:0]   res;
  logic               res_c, res_v;

  assign in_ready  = (state_q == S_IDLE);
  assign out       = out_q;
  assign out_valid = valid_q;
  assign carry_out = carry_q;
  assign zero_flag = zero_q;
  assign neg_flag  = neg_q;
  assign ovf_flag  = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    carry_d  = carry_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    res      = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;

    sum_add = {1'b0, RA} + {1'b0, RB};
    sum_sub = {1'b0, RA} + {1'b0, ~RB} + (WIDTH+1)'(1);
    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    acc_sum = acc_q + ({PW{mplier_q[0]}} & mcand_q);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          case (op)
            OP_ADD: begin
              res   = sum_add[WIDTH-1:0];
              res_c = sum_add[WIDTH];
              res_v = (RA[WIDTH-1] == RB[WIDTH-1]) && (res[WIDTH-1] != RA[WIDTH-1]);
            end
            OP_SUB: begin
              res   = sum_sub[WIDTH-1:0];
              res_c = sum_sub[WIDTH];
              res_v = (RA[WIDTH-1] != RB[WIDTH-1]) && (res[WIDTH-1] != RA[WIDTH-1]);
            end
            OP_AND: res = RA & RB;
            OP_OR:  res = RA | RB;
            OP_XOR: res = RA ^ RB;
            OP_SHL: begin
              res   = {RA[WIDTH-2:0], 1'b0};
              res_c = RA[WIDTH-1];
              res_v = RA[WIDTH-1] ^ RA[WIDTH-2];
            end
            OP_SHR: begin
              res   = {1'b0, RA[WIDTH-1:1]};
              res_c = RA[0];
            end
            default: begin
              state_d  = S_MUL;
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, RA};
              mplier_d = RB;
              cnt_d    = '0;
            end
          endcase
          if (op != OP_MUL) begin
            out_d   = res;
            carry_d = res_c;
            ovf_d   = res_v;
            zero_d  = (res == '0);
            neg_d   = res[WIDTH-1];
            valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_IDLE;
          out_d   = acc_sum[WIDTH-1:0];
          carry_d = |acc_sum[PW-1:WIDTH];
          ovf_d   = 1'b0;
          zero_d  = (acc_sum[WIDTH-1:0] == '0);
          neg_d   = acc_sum[WIDTH-1];
          valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16: expectations queued on issue,
// popped and compared whenever out_valid is seen.
module tb_alu_seq;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v8, rdy8, ov8, c8, z8, n8, f8;
  logic [2:0]  op8;
  logic [7:0]  ra8, rb8, out8;
  logic        v16, rdy16, ov16, c16, z16, n16, f16;
  logic [2:0]  op16;
  logic [15:0] ra16, rb16, out16;

  exp_t q8[$];
  exp_t q16[$];
  int   n_checks = 0;
  int   n_err    = 0;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .op(op8), .RA(ra8), .RB(rb8),
    .out(out8), .out_valid(ov8), .carry_out(c8), .zero_flag(z8), .neg_flag(n8), .ovf_flag(f8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .op(op16), .RA(ra16), .RB(rb16),
    .out(out16), .out_valid(ov16), .carry_out(c16), .zero_flag(z16), .neg_flag(n16), .ovf_flag(f16)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model built from plain wide integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input int w);
    logic [63:0] mask, s, r;
    exp_t e;
    mask = (64'd1 << w) - 64'd1;
    s = '0;
    r = '0;
    e = '0;
    case (op)
      3'd0: begin
        s = a + b; r = s & mask; e.c = s[w];
        e.v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      3'd1: begin
        s = a + (~b & mask) + 64'd1; r = s & mask; e.c = s[w];
        e.v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = (a << 1) & mask; e.c = a[w-1]; e.v = a[w-1] ^ a[w-2]; end
      3'd6: begin r = a >> 1; e.c = a[0]; end
      default: begin s = a * b; r = s & mask; e.c = ((s >> w) != 64'd0); end
    endcase
    e.res = r[31:0];
    e.z   = (r == 64'd0);
    e.n   = r[w-1];
    return e;
  endfunction

  always @(negedge clk) begin
    if (ov8) begin
      if (q8.size() == 0) check("spurious_valid8", 1, 0);
      else begin
        exp_t e;
        e = q8.pop_front();
        check("out8", out8, e.res);
        check("carry8", c8, e.c);
        check("zero8", z8, e.z);
        check("neg8", n8, e.n);
        check("ovf8", f8, e.v);
      end
    end
    if (ov16) begin
      if (q16.size() == 0) check("spurious_valid16", 1, 0);
      else begin
        exp_t e;
        e = q16.pop_front();
        check("out16", out16, e.res);
        check("carry16", c16, e.c);
        check("zero16", z16, e.z);
        check("neg16", n16, e.n);
        check("ovf16", f16, e.v);
      end
    end
  end

  // Called just after a falling edge; returns one cycle later, after the accept edge.
  task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    check("rdy8_before_issue", rdy8, 1);
    v8 = 1'b1; op8 = op; ra8 = a; rb8 = b;
    q8.push_back(model(op, 64'(a), 64'(b), 8));
    @(negedge clk);
    v8 = 1'b0;
  endtask

  task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    check("rdy16_before_issue", rdy16, 1);
    v16 = 1'b1; op16 = op; ra16 = a; rb16 = b;
    q16.push_back(model(op, 64'(a), 64'(b), 16));
    @(negedge clk);
    v16 = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    v8 = 1'b0; op8 = '0; ra8 = '0; rb8 = '0;
    v16 = 1'b0; op16 = '0; ra16 = '0; rb16 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_out8", out8, 0);
    check("reset_valid8", ov8, 0);
    check("reset_flags8", {c8, z8, n8, f8}, 0);
    check("reset_rdy8", rdy8, 1);
    check("reset_out16", out16, 0);

    // Single-cycle ops, back-to-back.
    issue8(3'd0, 8'h38, 8'h07);
    check("valid_after_add", ov8, 1);
    issue8(3'd0, 8'hFF, 8'h01);
    issue8(3'd0, 8'h7F, 8'h01);
    check("second_pulse", ov8, 1);
    issue8(3'd1, 8'h38, 8'h38);
    issue8(3'd1, 8'h07, 8'h38);
    issue8(3'd5, 8'h58, 8'h00);
    issue8(3'd6, 8'h58, 8'h00);
    issue8(3'd2, 8'hF0, 8'h3C);
    issue8(3'd3, 8'hF0, 8'h3C);
    issue8(3'd4, 8'hAA, 8'hAA);
    @(negedge clk);
    check("valid_pulse_ends", ov8, 0);
    check("out_holds", out8, 8'h00);
    for (int i = 0; i < 20; i++)
      issue8(3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom));
    @(negedge clk);

    // MUL with a competing request held while busy.
    issue8(3'd7, 8'h0C, 8'h0B);
    v8 = 1'b1; op8 = 3'd0; ra8 = 8'h01; rb8 = 8'h01;
    for (int i = 0; i < 8; i++) begin
      check("mul_busy_rdy", rdy8, 0);
      check("mul_busy_valid", ov8, 0);
      if (i == 7) v8 = 1'b0;
      @(negedge clk);
    end
    check("mul_valid_at_8", ov8, 1);
    check("mul_rdy_back", rdy8, 1);
    @(negedge clk);

    issue8(3'd7, 8'h10, 8'h10);
    cnt = 0;
    while (!ov8 && cnt < 40) begin @(negedge clk); cnt++; end
    check("mul8_latency", cnt, 8);
    @(negedge clk);

    // Reset three cycles into a multiply.
    issue8(3'd0, 8'h38, 8'h07);
    issue8(3'd7, 8'hFF, 8'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    void'(q8.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_out", out8, 0);
    check("abort_flags", {c8, z8, n8, f8}, 0);
    check("abort_valid", ov8, 0);
    check("abort_rdy", rdy8, 1);
    repeat (10) @(negedge clk);
    check("abort_no_late_valid", q8.size(), 0);

    // Reset beats a simultaneous request.
    rst = 1'b1; v8 = 1'b1; op8 = 3'd0; ra8 = 8'h05; rb8 = 8'h05;
    @(negedge clk);
    rst = 1'b0; v8 = 1'b0;
    @(negedge clk);
    check("rst_wins_valid", ov8, 0);
    check("rst_wins_out", out8, 0);
    issue8(3'd0, 8'h01, 8'h02);
    @(negedge clk);

    // WIDTH=16 instance.
    issue16(3'd0, 16'hFFFF, 16'h0001);
    issue16(3'd1, 16'h1234, 16'h4321);
    issue16(3'd0, 16'h7FFF, 16'h0001);
    issue16(3'd7, 16'h0100, 16'h0100);
    cnt = 0;
    while (!ov16 && cnt < 80) begin @(negedge clk); cnt++; end
    check("mul16_latency", cnt, 16);
    @(negedge clk);
    issue16(3'd7, 16'h00FF, 16'h0101);
    cnt = 0;
    while (!ov16 && cnt < 80) begin @(negedge clk); cnt++; end
    check("mul16b_latency", cnt, 16);
    repeat (3) @(negedge clk);

    check("q8_drained", q8.size(), 0);
    check("q16_drained", q16.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, handshaked successor to the single-cycle add/sub ALU of the 8-bit CPU datapath.
- Operand width is parametrised and the op set grows to eight operations, including a multi-cycle shift-add multiply.
- Results and a four-bit flag set (carry, zero, negative, overflow) are registered.
- Sits between the A/B registers and the bus driver. The controller issues one op per handshake and samples flags for conditional jumps.

Parameters:
WIDTH  8  operand/result width in bits (legal range 4..32)
CNT_W  $clog2(WIDTH)+1  width of the internal multiply iteration counter (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request this cycle
op  input  3  operation select (encoding below)
RA  input  WIDTH  operand A
RB  input  WIDTH  operand B
out  output  WIDTH  registered result
out_valid  output  1  one-cycle pulse; out and flags are new this cycle
carry_out  output  1  registered carry/borrow/shift-out flag
zero_flag  output  1  registered; 1 when out == 0
neg_flag  output  1  registered copy of out[WIDTH-1]
ovf_flag  output  1  registered signed-overflow flag

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: out=0, out_valid=0, all flags 0, state=IDLE, in_ready=1 in the cycle after reset.
- Accept: a request is accepted at any rising edge where in_valid && in_ready. op, RA and RB are sampled only at that edge.
- in_ready = (state == IDLE), driven combinationally from the state register.
- Requests presented while in_ready=0 are ignored, not queued.
- States:
  - IDLE: accept requests. Single-cycle ops stay in IDLE. op=111 goes to MUL.
  - MUL: WIDTH shift-add iterations, one per clock. On the final iteration, write the result and return to IDLE.
- Latency:
  - Single-cycle ops: out, flags and out_valid update at the accept edge, so out_valid is high for exactly the next cycle.
  - Back-to-back single-cycle accepts are allowed every cycle.
  - MUL: out_valid rises WIDTH edges after the accept edge. in_ready is low for WIDTH cycles and high again in the out_valid cycle.
- out and all flags hold their last value between results. out_valid=0 otherwise.
- Op encoding, with carry_out and ovf_flag rules:
  - 000 ADD: out = (RA+RB) mod 2^WIDTH. carry = bit WIDTH of the sum. ovf = signed overflow (operands same sign, result differs).
  - 001 SUB: out = RA + ~RB + 1. carry = carry of that sum (1 = no borrow, i.e. RA >= RB unsigned). ovf = operands differ in sign and result sign differs from RA.
  - 010 AND, 011 OR, 100 XOR: bitwise. carry = 0, ovf = 0.
  - 101 SHL: shift left by 1, zero fill. carry = RA[WIDTH-1]. ovf = RA[WIDTH-1] ^ RA[WIDTH-2].
  - 110 SHR: logical shift right by 1. carry = RA[0]. ovf = 0.
  - 111 MUL: unsigned; out = low WIDTH bits of RA*RB. carry = 1 if the high WIDTH bits of the product are nonzero. ovf = 0.
- zero_flag and neg_flag are derived from the written result for every op.
- MUL datapath:
  - Uses a 2*WIDTH-bit internal product accumulator and the CNT_W-bit counter.
  - Use the iterative shift-add structure, not a combinational multiplier.
  - RB=0 or RA=0 still takes the full WIDTH cycles.
- Reset mid-MUL: abort the multiply and clear the accumulator. Outputs return to reset values with no out_valid pulse, and the state returns to IDLE.
- Simultaneous rst and in_valid: rst wins and the request is dropped.
- An undefined op cannot occur (all 8 codes are defined).

Test Plan:
- WIDTH=8, ADD RA=0x38 RB=0x07 -> next cycle out=0x3F, out_valid=1, carry=0, zero=0, neg=0, ovf=0.
- ADD 0xFF+0x01 -> out=0x00, carry=1, zero=1. Then ADD 0x7F+0x01 back-to-back -> out=0x80, neg=1, ovf=1, carry=0. Two consecutive out_valid pulses.
- SUB 0x38-0x38 -> out=0x00, zero=1, carry=1. SUB 0x07-0x38 -> out=0xCF, carry=0, neg=1. SHL 0x58 -> out=0xB0, carry=0, ovf=1. SHR 0x58 -> out=0x2C.
- MUL 0x0C*0x0B -> in_ready low 8 cycles, out_valid exactly 8 edges after accept, out=0x84, carry=0. A request held during busy is ignored. MUL 0x10*0x10 -> out=0x00, carry=1, zero=1.
- Assert rst 3 cycles into a MUL -> no out_valid, out=0, flags=0, in_ready=1 the cycle after rst deasserts. A following ADD 0x01+0x02 -> 0x03.
- Re-run ADD, SUB and MUL checks at WIDTH=16: 0xFFFF+0x0001 -> 0x0000 carry=1; MUL 0x0100*0x0100 -> carry=1 after 16 cycles.
